// File: rtl/sgbm_system.sv
// rtl/sgbm_system.sv - synthetic stereo pair, AD cost and left-to-right SGM aggregation
module sgbm_system #(
    parameter int IMAGE_ROW = 200,
    parameter int IMAGE_COL = 400,
    parameter int DISP_NUM  = 48,
    parameter int COST_W    = 18,
    parameter int TRUE_DISP = 16,
    parameter int P1        = 10,
    parameter int P2        = 120,
    parameter int CMAX      = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [COST_W*DISP_NUM-1:0]   sgbm_cost,
    output logic [9:0]                   sgbm_row,
    output logic [9:0]                   sgbm_col,
    output logic                         sgbm_valid
);

    localparam logic [9:0]        LAST_COL   = 10'(IMAGE_COL - 1);
    localparam logic [9:0]        LAST_ROW   = 10'(IMAGE_ROW - 1);
    localparam logic [7:0]        CMAX8      = 8'(CMAX);
    // R(r,c) = L(r,c+TRUE_DISP) reduces to a constant offset mod 256
    localparam logic [7:0]        DISP_SHIFT = 8'((37 * TRUE_DISP) % 256);
    localparam logic [COST_W-1:0] P1_W       = COST_W'(P1);
    localparam logic [COST_W-1:0] P2_W       = COST_W'(P2);

    // S0 state
    logic [9:0] row0, col0;
    logic [7:0] left_pix, right_pix;
    logic [7:0] hist [DISP_NUM-1];

    // S1 state
    logic [8*DISP_NUM-1:0] cost1;
    logic [9:0]            row1, col1;
    logic                  v1;

    logic [8*DISP_NUM-1:0]      cost_next;
    logic [COST_W*DISP_NUM-1:0] agg_next;
    logic [COST_W-1:0]          mp;

    // Raster scan counters, one pixel per cycle, wrapping forever
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row0 <= '0;
            col0 <= '0;
        end else if (col0 == LAST_COL) begin
            col0 <= '0;
            row0 <= (row0 == LAST_ROW) ? 10'd0 : row0 + 10'd1;
        end else begin
            col0 <= col0 + 10'd1;
        end
    end

    // Synthetic pixel pair for the current scan position
    always_comb begin
        left_pix  = 8'(37 * col0 + 11 * row0);
        right_pix = left_pix + DISP_SHIFT;
    end

    // History of previous right pixels; stale entries from the prior row are masked by c>=d
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DISP_NUM - 1; k++) hist[k] <= '0;
        end else begin
            hist[0] <= right_pix;
            for (int k = 1; k < DISP_NUM - 1; k++) hist[k] <= hist[k-1];
        end
    end

    genvar d;
    for (d = 0; d < DISP_NUM; d++) begin : g_lane
        logic [7:0]        rv;
        logic [COST_W-1:0] lp, best_a, best_b, best_c, c_ext;

        if (d == 0) begin : g_r0
            assign rv = right_pix;
        end else begin : g_rn
            assign rv = hist[d-1];
        end

        assign cost_next[8*d +: 8] = (col0 >= 10'(d))
                                   ? ((left_pix > rv) ? left_pix - rv : rv - left_pix)
                                   : CMAX8;

        assign lp    = sgbm_cost[COST_W*d +: COST_W];
        assign c_ext = COST_W'(cost1[8*d +: 8]);

        if (d == 0) begin : g_lo_edge
            assign best_a = lp;
        end else begin : g_lo
            logic [COST_W-1:0] nb;
            assign nb     = sgbm_cost[COST_W*(d-1) +: COST_W] + P1_W;
            assign best_a = (nb < lp) ? nb : lp;
        end

        if (d == DISP_NUM - 1) begin : g_hi_edge
            assign best_b = best_a;
        end else begin : g_hi
            logic [COST_W-1:0] nb;
            assign nb     = sgbm_cost[COST_W*(d+1) +: COST_W] + P1_W;
            assign best_b = (nb < best_a) ? nb : best_a;
        end

        assign best_c = ((mp + P2_W) < best_b) ? (mp + P2_W) : best_b;

        // Column 0 starts a fresh path so nothing carries across rows
        assign agg_next[COST_W*d +: COST_W] = (col1 == 10'd0) ? c_ext : c_ext + best_c - mp;
    end

    // Minimum over all lanes of the previous pixel
    always_comb begin
        mp = sgbm_cost[COST_W-1:0];
        for (int i = 1; i < DISP_NUM; i++) begin
            if (sgbm_cost[COST_W*i +: COST_W] < mp) mp = sgbm_cost[COST_W*i +: COST_W];
        end
    end

    // S1: matching cost and position register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cost1 <= '0;
            row1  <= '0;
            col1  <= '0;
            v1    <= 1'b0;
        end else begin
            cost1 <= cost_next;
            row1  <= row0;
            col1  <= col0;
            v1    <= 1'b1;
        end
    end

    // S2: aggregated costs drive the outputs directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgbm_cost  <= '0;
            sgbm_row   <= '0;
            sgbm_col   <= '0;
            sgbm_valid <= 1'b0;
        end else begin
            sgbm_cost  <= agg_next;
            sgbm_row   <= row1;
            sgbm_col   <= col1;
            sgbm_valid <= v1;
        end
    end

endmodule

// File: tb/tb_sgbm_system.sv
// tb/tb_sgbm_system.sv - directed and golden-model bench for sgbm_system
module tb_sgbm_system;

    localparam int W = 18;
    localparam int N = 48;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W*N-1:0] sgbm_cost;
    logic [9:0]     sgbm_row;
    logic [9:0]     sgbm_col;
    logic           sgbm_valid;

    int errors = 0;
    int checks = 0;
    int lp [N];
    int er, ec;

    sgbm_system dut (
        .clk        (clk),
        .rst        (rst),
        .sgbm_cost  (sgbm_cost),
        .sgbm_row   (sgbm_row),
        .sgbm_col   (sgbm_col),
        .sgbm_valid (sgbm_valid)
    );

    always #5 clk = ~clk;

    function automatic int lpix(int r, int c);
        return (37 * c + 11 * r) % 256;
    endfunction

    function automatic int rpix(int r, int c);
        return lpix(r, c + 16);
    endfunction

    function automatic int absd(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int lane(int d);
        return int'(sgbm_cost[W*d +: W]);
    endfunction

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sgbm_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_one_edge got=%0b want=0", sgbm_valid);
        end
        @(negedge clk);
    endtask

    task automatic check_first_pixel(string tag);
        int bad;
        checks++;
        if (sgbm_valid !== 1'b1 || sgbm_row !== 10'd0 || sgbm_col !== 10'd0) begin
            errors++;
            $display("FAIL %s_pos valid=%0b row=%0d col=%0d want 1,0,0", tag, sgbm_valid, sgbm_row, sgbm_col);
        end
        checks++;
        if (lane(0) !== 80) begin
            errors++;
            $display("FAIL %s_lane0 got=%0d want=80", tag, lane(0));
        end
        bad = -1;
        for (int d = 1; d < N; d++) if (lane(d) !== 255 && bad < 0) bad = d;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_lanes lane%0d got=%0d want=255", tag, bad, lane(bad));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            checks++;
            if (sgbm_valid !== 1'b0 || sgbm_row !== 10'd0 || sgbm_col !== 10'd0 || sgbm_cost !== '0) begin
                errors++;
                $display("FAIL reset_hold valid=%0b row=%0d col=%0d lane0=%0d want all 0",
                         sgbm_valid, sgbm_row, sgbm_col, lane(0));
            end
        end
    endtask

    task automatic test_first_pixel();
        release_rst();
        check_first_pixel("first");
    endtask

    task automatic test_stream(int npix);
        int cc [N];
        int nl [N];
        int mp, m, bad;
        er = 0;
        ec = 0;
        for (int p = 0; p < npix; p++) begin
            for (int d = 0; d < N; d++)
                cc[d] = (ec >= d) ? absd(lpix(er, ec), rpix(er, ec - d)) : 255;
            if (ec == 0) begin
                for (int d = 0; d < N; d++) nl[d] = cc[d];
            end else begin
                mp = lp[0];
                for (int d = 1; d < N; d++) if (lp[d] < mp) mp = lp[d];
                for (int d = 0; d < N; d++) begin
                    m = lp[d];
                    if (d > 0 && lp[d-1] + 10 < m) m = lp[d-1] + 10;
                    if (d < N - 1 && lp[d+1] + 10 < m) m = lp[d+1] + 10;
                    if (mp + 120 < m) m = mp + 120;
                    nl[d] = cc[d] + m - mp;
                end
            end

            checks++;
            if (sgbm_valid !== 1'b1 || int'(sgbm_row) != er || int'(sgbm_col) != ec) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL raster valid=%0b row=%0d col=%0d want 1,%0d,%0d",
                             sgbm_valid, sgbm_row, sgbm_col, er, ec);
            end

            bad = -1;
            for (int d = 0; d < N; d++) if (lane(d) != nl[d] && bad < 0) bad = d;
            checks++;
            if (bad >= 0) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL golden (%0d,%0d) lane%0d got=%0d want=%0d", er, ec, bad, lane(bad), nl[bad]);
            end

            bad = -1;
            for (int d = 0; d < N; d++) if ((lane(d) < cc[d] || lane(d) > 375) && bad < 0) bad = d;
            checks++;
            if (bad >= 0) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL bounds (%0d,%0d) lane%0d got=%0d want %0d..375", er, ec, bad, lane(bad), cc[bad]);
            end

            if (ec == 399) begin
                bad = -1;
                for (int d = 0; d < N; d++) if (d != 16 && lane(d) < 3 && bad < 0) bad = d;
                checks++;
                if (lane(16) != 0 || bad >= 0) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL converge row=%0d lane16=%0d want 0, low lane=%0d want >=3", er, lane(16), bad);
                end
            end

            if (ec == 0 && er >= 1) begin
                bad = -1;
                for (int d = 1; d < N; d++) if (lane(d) != 255 && bad < 0) bad = d;
                checks++;
                if (lane(0) != absd(lpix(er, 0), lpix(er, 16)) || bad >= 0) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL row_isolation row=%0d lane0=%0d want=%0d bad_lane=%0d",
                                 er, lane(0), absd(lpix(er, 0), lpix(er, 16)), bad);
                end
            end

            for (int d = 0; d < N; d++) lp[d] = nl[d];
            if (ec == 399) begin
                ec = 0;
                er = (er == 199) ? 0 : er + 1;
            end else begin
                ec++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (sgbm_valid !== 1'b0 || sgbm_row !== 10'd0 || sgbm_col !== 10'd0 || sgbm_cost !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%0b row=%0d col=%0d want 0,0,0", sgbm_valid, sgbm_row, sgbm_col);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sgbm_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_hold valid=%0b want=0", sgbm_valid);
        end
    endtask

    task automatic test_restart();
        release_rst();
        check_first_pixel("restart");
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_stream(80002);
        test_async_reset();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
